alarm_bank: RTL and testbench
=============================

ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 Parameter NUM_ALARMS, default 4, sets the number of alarm slots (legal range 1..16).
REQ-002 Parameter RING_SECS, default 60, sets the maximum ring duration in secTick pulses (legal range 1..255).
REQ-003 Parameter SNOOZE_MIN, default 5, sets the snooze delay in minutes (legal range 1..59).
REQ-004 clk  in  1  sole clock; every register is updated on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 secTick  in  1  one-cycle pulse once per second.
REQ-007 curTime  in  16  current time, BCD {H1,H0,M1,M0}, 00:00..23:59.
REQ-008 setTime  in  16  alarm time to store, BCD {H1,H0,M1,M0}.
REQ-009 alarmSel  in  SELW  slot index, where SELW = max(1, clog2(NUM_ALARMS)).
REQ-010 alarmSet  in  1  stores setTime into slot alarmSel and marks the slot enabled.
REQ-011 alarmClear  in  1  disables slot alarmSel and zeroes its stored time.
REQ-012 stop  in  1  ends ringing or snooze.
REQ-013 snooze  in  1  requests snooze while ringing.
REQ-014 alarm  out  1  high while in RINGING.
REQ-015 alarmId  out  SELW  index of the slot that fired; held until the next fire.
REQ-016 dispTime  out  16  stored time of slot alarmSel, registered.
REQ-017 dispEn  out  1  enable flag of slot alarmSel, registered.

Function
REQ-018 Each slot shall hold a 16-bit BCD time and one enable bit.
REQ-019 Matching shall be evaluated only in the cycle after curTime changes: curTime is registered and the current value is compared with the registered value; a level match shall not re-fire within the same minute.
REQ-020 A slot shall match when it is enabled and its stored time equals curTime on all 16 bits.
REQ-021 If several slots match at once, the lowest index shall win and be loaded into alarmId.
REQ-022 The FSM shall have the states IDLE, RINGING and SNOOZED.
REQ-023 IDLE -> RINGING on a match; the ring counter is cleared on entry.
REQ-024 RINGING -> IDLE on stop, or when the ring counter reaches RING_SECS secTick pulses.
REQ-025 RINGING -> SNOOZED on snooze; the snooze target shall be loaded as curTime + SNOOZE_MIN.
REQ-026 SNOOZED -> RINGING when a time change makes curTime equal the snooze target, or on any slot match (which reloads alarmId).
REQ-027 SNOOZED -> IDLE on stop.
REQ-028 In RINGING, new matches shall be ignored and alarmId shall be held.
REQ-029 If stop and snooze are asserted in the same cycle, stop shall win.
REQ-030 Snooze target arithmetic shall be BCD:
- minutes wrap 59 -> 00 with a carry into hours;
- hours wrap 23 -> 00.
REQ-031 If alarmClear and alarmSet are asserted in the same cycle, alarmClear shall win.
REQ-032 Slot writes shall take effect on the next clock edge and may occur in any FSM state.
REQ-033 Clearing the slot that is currently ringing shall not stop the ring.
REQ-034 dispTime and dispEn shall have 1-cycle latency from alarmSel or from a slot write.
REQ-035 An alarmSel value >= NUM_ALARMS shall make set/clear a no-op and shall drive dispTime = 0 and dispEn = 0.

Reset
REQ-036 Reset shall have priority over all other inputs.
REQ-037 Reset shall clear:
- all slots: time 0, disabled;
- the FSM, to IDLE;
- the ring counter and the snooze target, to 0;
- the registered curTime, loaded with curTime itself so that no match occurs on the first cycle after reset;
- the outputs alarm = 0, alarmId = 0, dispTime = 0, dispEn = 0.
REQ-038 Reset asserted mid-ring shall drop alarm in the same cycle that reset is sampled.

Configuration
REQ-039 Macro ALARM_SNOOZE_EN:
- when defined, the SNOOZED state, the snooze target register and the BCD adder shall be present;
- when undefined, the snooze input shall be ignored, no SNOOZED state or adder logic shall exist, and RINGING shall exit only via stop or timeout.

Structure
REQ-040 Shared package alarm_pkg shall hold:
- the FSM state enum;
- the bcd_time_t 16-bit typedef;
- the constants MAX_HOUR_BCD = 8'h23 and MAX_MIN_BCD = 8'h59.
REQ-041 The combinational sub-module bcd_time_add (time plus minutes, with wrap) shall be instantiated only under ALARM_SNOOZE_EN.

Verification
REQ-042 Set slot 2 = 07:30 and step curTime 07:29 -> 07:30: alarm rises one cycle after the change, alarmId = 2, and the alarm does not re-fire while curTime is held at 07:30.
REQ-043 Slots 1 and 3 both = 12:00, curTime -> 12:00: alarmId = 1.
REQ-044 Ring with RING_SECS = 3 and send 3 secTick pulses: alarm falls after the 3rd pulse and the state is IDLE.
REQ-045 Ring at 23:58 and pulse snooze (SNOOZE_MIN = 5): the snooze target is 00:03, and alarm re-rises when curTime becomes 00:03.
REQ-046 Assert stop and snooze together while ringing: the state goes to IDLE; assert alarmSet and alarmClear together on slot 0: the slot ends disabled.
REQ-047 Assert reset mid-ring: alarm = 0 and dispEn = 0, and no fire occurs even though curTime still equals the old alarm time.

Source files
------------

// File: rtl/alarm_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg
// Shared types and constants for the alarm bank.
//   alarm_state_t  : FSM state encoding (SNOOZED only exists when the
//                    ALARM_SNOOZE_EN macro is defined)
//   bcd_time_t     : 16-bit BCD time {H1,H0,M1,M0}
//   MAX_HOUR_BCD / MAX_MIN_BCD : last legal hour / minute in BCD
//   bcd8_to_bin / bin_to_bcd8  : two-digit BCD <-> binary helpers
// ---------------------------------------------------------------------------
package alarm_pkg;

    typedef logic [15:0] bcd_time_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1
`ifdef ALARM_SNOOZE_EN
        ,
        ST_SNOOZED = 2'd2
`endif
    } alarm_state_t;

    localparam logic [7:0] MAX_HOUR_BCD = 8'h23;
    localparam logic [7:0] MAX_MIN_BCD  = 8'h59;

    // Two BCD digits (00..99) to binary.
    function automatic logic [6:0] bcd8_to_bin(input logic [7:0] b);
        return ({3'b000, b[7:4]} * 7'd10) + {3'b000, b[3:0]};
    endfunction

    // Binary 0..99 to two BCD digits.
    function automatic logic [7:0] bin_to_bcd8(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 7'd10);
        ones = 4'(v % 7'd10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd_time_add.sv
// ---------------------------------------------------------------------------
// bcd_time_add
// Combinational BCD clock adder: o_time = i_time + ADD_MIN minutes.
// Minutes wrap 59 -> 00 with a carry into hours; hours wrap 23 -> 00.
// Ports:
//   i_time : input  bcd_time_t  time {H1,H0,M1,M0}
//   o_time : output bcd_time_t  time advanced by ADD_MIN minutes
// Parameter ADD_MIN must be 0..59, so at most one hour carry can occur.
// ---------------------------------------------------------------------------
module bcd_time_add
    import alarm_pkg::*;
#(
    parameter int ADD_MIN = 5
) (
    input  bcd_time_t i_time,
    output bcd_time_t o_time
);

    logic [6:0] w_min_sum;
    logic [6:0] w_hr_sum;

    always_comb begin
        w_min_sum = bcd8_to_bin(i_time[7:0]) + 7'(ADD_MIN);
        w_hr_sum  = bcd8_to_bin(i_time[15:8]);
        if (w_min_sum > bcd8_to_bin(MAX_MIN_BCD)) begin
            w_min_sum = w_min_sum - (bcd8_to_bin(MAX_MIN_BCD) + 7'd1);
            w_hr_sum  = w_hr_sum + 7'd1;
        end
        if (w_hr_sum > bcd8_to_bin(MAX_HOUR_BCD)) begin
            w_hr_sum = w_hr_sum - (bcd8_to_bin(MAX_HOUR_BCD) + 7'd1);
        end
        o_time = {bin_to_bcd8(w_hr_sum), bin_to_bcd8(w_min_sum)};
    end

endmodule

// File: rtl/alarm_bank.sv
// ---------------------------------------------------------------------------
// alarm_bank
// Bank of NUM_ALARMS alarm slots compared against a BCD wall clock, with a
// ring FSM (IDLE / RINGING, plus SNOOZED when ALARM_SNOOZE_EN is defined).
// Optional feature macro: ALARM_SNOOZE_EN (snooze state, target register and
// BCD adder). Without it, the snooze input is ignored.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   secTick        : one-cycle pulse per second, drives the ring timeout
//   curTime        : current BCD time {H1,H0,M1,M0}
//   setTime        : BCD time written by alarmSet
//   alarmSel       : slot index for set/clear/display
//   alarmSet       : store setTime into slot alarmSel and enable it
//   alarmClear     : disable slot alarmSel and zero its time (wins over set)
//   stop, snooze   : ring control (stop wins over snooze)
//   alarm          : high while RINGING
//   alarmId        : slot that last fired
//   dispTime/dispEn: registered view of slot alarmSel (0 for out-of-range)
//   o_dbg_state    : current FSM state encoding
// Handshake: there is no valid/ready flow; every input is a level or pulse
// sampled on the rising clock edge.
// ---------------------------------------------------------------------------
module alarm_bank
    import alarm_pkg::*;
#(
    parameter  int NUM_ALARMS = 4,
    parameter  int RING_SECS  = 60,
    parameter  int SNOOZE_MIN = 5,
    localparam int SELW       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            secTick,
    input  logic [15:0]     curTime,
    input  logic [15:0]     setTime,
    input  logic [SELW-1:0] alarmSel,
    input  logic            alarmSet,
    input  logic            alarmClear,
    input  logic            stop,
    input  logic            snooze,
    output logic            alarm,
    output logic [SELW-1:0] alarmId,
    output logic [15:0]     dispTime,
    output logic            dispEn,
    output logic [1:0]      o_dbg_state
);

    bcd_time_t              r_slot_time [NUM_ALARMS];
    logic [NUM_ALARMS-1:0]  r_slot_en;
    bcd_time_t              r_cur_time;
    alarm_state_t           r_state;
    alarm_state_t           w_state_nxt;
    logic [7:0]             r_ring_cnt;
    logic [7:0]             w_ring_cnt_nxt;
    logic [SELW-1:0]        r_alarm_id;
    logic [SELW-1:0]        w_alarm_id_nxt;
    bcd_time_t              r_disp_time;
    bcd_time_t              w_disp_time_nxt;
    logic                   r_disp_en;
    logic                   w_disp_en_nxt;

    logic                   w_time_changed;
    logic [NUM_ALARMS-1:0]  w_match;
    logic                   w_any_match;
    logic [SELW-1:0]        w_hit_id;

`ifdef ALARM_SNOOZE_EN
    bcd_time_t              r_snz_target;
    bcd_time_t              w_snz_target_nxt;
    bcd_time_t              w_snz_sum;

    bcd_time_add #(
        .ADD_MIN (SNOOZE_MIN)
    ) u_snz_add (
        .i_time (curTime),
        .o_time (w_snz_sum)
    );
`else
    logic                   w_unused_snooze;
    assign w_unused_snooze = snooze;
`endif

    // Matches only count in the cycle where curTime differs from its
    // registered copy, so a held minute fires once.
    assign w_time_changed = (curTime != r_cur_time);

    always_comb begin
        w_hit_id = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            w_match[i] = r_slot_en[i] && (r_slot_time[i] == curTime);
        end
        // Descending scan so the lowest matching index is assigned last.
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit_id = i[SELW-1:0];
            end
        end
        w_any_match = w_time_changed && (|w_match);
    end

    // Next-state logic
    always_comb begin
        w_state_nxt    = r_state;
        w_ring_cnt_nxt = r_ring_cnt;
        w_alarm_id_nxt = r_alarm_id;
`ifdef ALARM_SNOOZE_EN
        w_snz_target_nxt = r_snz_target;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_any_match) begin
                    w_state_nxt    = ST_RINGING;
                    w_ring_cnt_nxt = 8'd0;
                    w_alarm_id_nxt = w_hit_id;
                end
            end
            ST_RINGING: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze) begin
                    w_state_nxt      = ST_SNOOZED;
                    w_snz_target_nxt = w_snz_sum;
`endif
                end else if (secTick) begin
                    if (r_ring_cnt == 8'(RING_SECS - 1)) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ring_cnt_nxt = r_ring_cnt + 8'd1;
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZED: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_any_match) begin
                    w_state_nxt    = ST_RINGING;
                    w_ring_cnt_nxt = 8'd0;
                    w_alarm_id_nxt = w_hit_id;
                end else if (w_time_changed && (curTime == r_snz_target)) begin
                    w_state_nxt    = ST_RINGING;
                    w_ring_cnt_nxt = 8'd0;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Display view of the selected slot, forwarding a same-cycle write so
    // the display follows a write with the same one-cycle latency as a
    // select change. Out-of-range selects match no slot and show zero.
    always_comb begin
        w_disp_time_nxt = '0;
        w_disp_en_nxt   = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (int'(alarmSel) == i) begin
                if (alarmClear) begin
                    w_disp_time_nxt = '0;
                    w_disp_en_nxt   = 1'b0;
                end else if (alarmSet) begin
                    w_disp_time_nxt = setTime;
                    w_disp_en_nxt   = 1'b1;
                end else begin
                    w_disp_time_nxt = r_slot_time[i];
                    w_disp_en_nxt   = r_slot_en[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                r_slot_time[i] <= '0;
            end
            r_slot_en   <= '0;
            // Loading the live value means no time change is seen right
            // after reset, so nothing fires on the first cycle.
            r_cur_time  <= curTime;
            r_state     <= ST_IDLE;
            r_ring_cnt  <= 8'd0;
            r_alarm_id  <= '0;
            r_disp_time <= '0;
            r_disp_en   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            r_snz_target <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (int'(alarmSel) == i) begin
                    if (alarmClear) begin
                        r_slot_time[i] <= '0;
                        r_slot_en[i]   <= 1'b0;
                    end else if (alarmSet) begin
                        r_slot_time[i] <= setTime;
                        r_slot_en[i]   <= 1'b1;
                    end
                end
            end
            r_cur_time  <= curTime;
            r_state     <= w_state_nxt;
            r_ring_cnt  <= w_ring_cnt_nxt;
            r_alarm_id  <= w_alarm_id_nxt;
            r_disp_time <= w_disp_time_nxt;
            r_disp_en   <= w_disp_en_nxt;
`ifdef ALARM_SNOOZE_EN
            r_snz_target <= w_snz_target_nxt;
`endif
        end
    end

    assign alarm       = (r_state == ST_RINGING);
    assign alarmId     = r_alarm_id;
    assign dispTime    = r_disp_time;
    assign dispEn      = r_disp_en;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alarm_bank.sv
// ---------------------------------------------------------------------------
// tb_alarm_bank
// Directed bench for alarm_bank (NUM_ALARMS=4, RING_SECS=3, SNOOZE_MIN=5).
// Inputs change 1 ns after a rising edge; outputs are checked at the same
// point, i.e. they show the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_alarm_bank;

    localparam int NUM_ALARMS = 4;
    localparam int SELW       = 2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RINGING = 2'd1;
    localparam logic [1:0] S_SNOOZED = 2'd2;

    logic            clk = 1'b0;
    logic            reset;
    logic            secTick;
    logic [15:0]     curTime;
    logic [15:0]     setTime;
    logic [SELW-1:0] alarmSel;
    logic            alarmSet;
    logic            alarmClear;
    logic            stop;
    logic            snooze;
    logic            alarm;
    logic [SELW-1:0] alarmId;
    logic [15:0]     dispTime;
    logic            dispEn;
    logic [1:0]      dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    alarm_bank #(
        .NUM_ALARMS (NUM_ALARMS),
        .RING_SECS  (3),
        .SNOOZE_MIN (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .secTick     (secTick),
        .curTime     (curTime),
        .setTime     (setTime),
        .alarmSel    (alarmSel),
        .alarmSet    (alarmSet),
        .alarmClear  (alarmClear),
        .stop        (stop),
        .snooze      (snooze),
        .alarm       (alarm),
        .alarmId     (alarmId),
        .dispTime    (dispTime),
        .dispEn      (dispEn),
        .o_dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_slot(input logic [SELW-1:0] sel, input logic [15:0] t);
        alarmSel = sel;
        setTime  = t;
        alarmSet = 1'b1;
        step();
        alarmSet = 1'b0;
    endtask

    task automatic set_time(input logic [15:0] t);
        curTime = t;
        step();
    endtask

    task automatic pulse_tick();
        secTick = 1'b1;
        step();
        secTick = 1'b0;
        step();
    endtask

    initial begin
        reset      = 1'b1;
        secTick    = 1'b0;
        curTime    = 16'h0000;
        setTime    = 16'h0000;
        alarmSel   = '0;
        alarmSet   = 1'b0;
        alarmClear = 1'b0;
        stop       = 1'b0;
        snooze     = 1'b0;
        step(2);
        reset = 1'b0;
        step();

        // reset state
        check_eq("rst_alarm",   alarm,     0);
        check_eq("rst_id",      alarmId,   0);
        check_eq("rst_disp",    dispTime,  0);
        check_eq("rst_dispen",  dispEn,    0);
        check_eq("rst_state",   dbg_state, S_IDLE);

        // single slot fire, no re-fire within the held minute
        write_slot(2, 16'h0730);
        check_eq("set_disp",    dispTime, 16'h0730);
        check_eq("set_dispen",  dispEn,   1);
        set_time(16'h0729);
        check_eq("pre_alarm",   alarm,    0);
        set_time(16'h0730);
        check_eq("fire_alarm",  alarm,    1);
        check_eq("fire_id",     alarmId,  2);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("stop_alarm",  alarm,    0);
        step(3);
        check_eq("no_refire",   alarm,    0);

        // priority: lowest index wins
        write_slot(1, 16'h1200);
        write_slot(3, 16'h1200);
        check_eq("sel3_disp",   dispTime, 16'h1200);
        set_time(16'h1159);
        check_eq("pri_pre",     alarm,    0);
        set_time(16'h1200);
        check_eq("pri_alarm",   alarm,    1);
        check_eq("pri_id",      alarmId,  1);

        // timeout after three secTick pulses
        pulse_tick();
        pulse_tick();
        check_eq("tick2_alarm", alarm,    1);
        secTick = 1'b1;
        step();
        secTick = 1'b0;
        check_eq("tick3_alarm", alarm,    0);
        check_eq("tick3_state", dbg_state, S_IDLE);

        // snooze across midnight
        write_slot(0, 16'h2358);
        set_time(16'h2357);
        set_time(16'h2358);
        check_eq("snz_ring",    alarm,    1);
        check_eq("snz_id",      alarmId,  0);
        snooze = 1'b1;
        step();
        snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
        check_eq("snz_state",   dbg_state, S_SNOOZED);
        check_eq("snz_alarm",   alarm,    0);
        set_time(16'h2359);
        set_time(16'h0000);
        set_time(16'h0001);
        set_time(16'h0002);
        check_eq("snz_0002",    alarm,    0);
        set_time(16'h0003);
        check_eq("snz_0003",    alarm,    1);
        check_eq("snz_id_hold", alarmId,  0);
`else
        check_eq("nosnz_state", dbg_state, S_RINGING);
        check_eq("nosnz_alarm", alarm,    1);
`endif
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("snz_stop",    dbg_state, S_IDLE);

        // clear while ringing, then stop+snooze together
        set_time(16'h0729);
        set_time(16'h0730);
        check_eq("ring2_alarm", alarm,    1);
        check_eq("ring2_id",    alarmId,  2);
        alarmSel   = 2;
        alarmClear = 1'b1;
        step();
        alarmClear = 1'b0;
        check_eq("clr_ring",    alarm,    1);
        check_eq("clr_dispen",  dispEn,   0);
        check_eq("clr_disp",    dispTime, 0);
        stop   = 1'b1;
        snooze = 1'b1;
        step();
        stop   = 1'b0;
        snooze = 1'b0;
        check_eq("ss_state",    dbg_state, S_IDLE);
        check_eq("ss_alarm",    alarm,    0);

        // set and clear together on slot 0
        alarmSel   = 0;
        setTime    = 16'h1111;
        alarmSet   = 1'b1;
        alarmClear = 1'b1;
        step();
        alarmSet   = 1'b0;
        alarmClear = 1'b0;
        check_eq("sc_dispen",   dispEn,   0);
        check_eq("sc_disp",     dispTime, 0);
        step();
        check_eq("sc_dispen2",  dispEn,   0);

        // select latency
        alarmSel = 1;
        step();
        check_eq("sel1_disp",   dispTime, 16'h1200);
        check_eq("sel1_dispen", dispEn,   1);

        // reset mid-ring
        set_time(16'h1159);
        set_time(16'h1200);
        check_eq("mr_alarm",    alarm,    1);
        check_eq("mr_id",       alarmId,  1);
        reset = 1'b1;
        step();
        check_eq("mr_rst_alarm", alarm,   0);
        check_eq("mr_rst_dispen", dispEn, 0);
        check_eq("mr_rst_id",   alarmId,  0);
        reset = 1'b0;
        step(2);
        check_eq("mr_post",     alarm,    0);
        write_slot(1, 16'h1200);
        step(2);
        check_eq("mr_held",     alarm,    0);
        check_eq("mr_held_st",  dbg_state, S_IDLE);
        set_time(16'h1201);
        set_time(16'h1200);
        check_eq("mr_refire",   alarm,    1);
        check_eq("mr_refire_id", alarmId, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
